regfile_operand_fetch: RTL and testbench

Initiator-side controller for the 16 x 20-bit synchronous register file: it accepts two-source operand fetch requests, drives the file's two read ports, and absorbs the file's one-cycle registered read latency. It also passes writebacks to the write port. It forwards any write that collides with an in-flight or held read, so every delivered operand equals the architecturally current register value. It sits between the instruction decode stage (upstream) and the execute stage (downstream).

---
 rtl/regfile_operand_fetch.sv | 103 ++++++++++
 tb/tb_regfile_operand_fetch.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_operand_fetch.sv
// Operand fetch front-end for the 16 x 20-bit register file: drives both read
// ports, absorbs the one-cycle read latency and forwards colliding writebacks.
module regfile_operand_fetch (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_src0,
  input  logic [3:0]  in_src1,
  input  logic        wb_valid,
  input  logic [3:0]  wb_addr,
  input  logic [19:0] wb_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [19:0] out_op0,
  output logic [19:0] out_op1,
  output logic        rf_wr_en,
  output logic [3:0]  rf_wr_addr,
  output logic [19:0] rf_wr_data,
  output logic [3:0]  rf_rd0_addr,
  output logic [3:0]  rf_rd1_addr,
  input  logic [19:0] rf_rd0_data,
  input  logic [19:0] rf_rd1_data
);

  // state | meaning
  // IDLE  | no request held, ready for a new fetch
  // READ  | file is returning data for latched s0/s1
  // HOLD  | operands valid, waiting for downstream
  typedef enum logic [1:0] {IDLE, READ, HOLD} state_t;

  state_t      state;
  logic [3:0]  s0, s1;
  logic        fwd0, fwd1;
  logic [19:0] fwd_data0, fwd_data1;

  logic accept;
  logic wb_hit_in0, wb_hit_in1, wb_hit_s0, wb_hit_s1;

  assign in_ready   = (state == IDLE) | ((state == HOLD) & out_ready);
  assign accept     = in_valid & in_ready;

  assign wb_hit_in0 = wb_valid & (wb_addr == in_src0);
  assign wb_hit_in1 = wb_valid & (wb_addr == in_src1);
  assign wb_hit_s0  = wb_valid & (wb_addr == s0);
  assign wb_hit_s1  = wb_valid & (wb_addr == s1);

  assign rf_wr_en    = wb_valid;
  assign rf_wr_addr  = wb_addr;
  assign rf_wr_data  = wb_data;

  assign rf_rd0_addr = accept ? in_src0 : s0;
  assign rf_rd1_addr = accept ? in_src1 : s1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_op0   <= '0;
      out_op1   <= '0;
      s0        <= '0;
      s1        <= '0;
      fwd0      <= 1'b0;
      fwd1      <= 1'b0;
      fwd_data0 <= '0;
      fwd_data1 <= '0;
    end else begin
      // A write in the accept cycle lands after the file samples the address,
      // so the file would return the stale value; remember the new one.
      if (accept) begin
        s0        <= in_src0;
        s1        <= in_src1;
        fwd0      <= wb_hit_in0;
        fwd1      <= wb_hit_in1;
        fwd_data0 <= wb_data;
        fwd_data1 <= wb_data;
      end

      case (state)
        IDLE: begin
          if (accept) state <= READ;
        end
        READ: begin
          out_op0   <= wb_hit_s0 ? wb_data : (fwd0 ? fwd_data0 : rf_rd0_data);
          out_op1   <= wb_hit_s1 ? wb_data : (fwd1 ? fwd_data1 : rf_rd1_data);
          out_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= in_valid ? READ : IDLE;
          end else begin
            if (wb_hit_s0) out_op0 <= wb_data;
            if (wb_hit_s1) out_op1 <= wb_data;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_operand_fetch.sv
// Self-checking bench for regfile_operand_fetch with a behavioural register
// file model and an operand scoreboard.
module tb_regfile_operand_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [3:0]  in_src0, in_src1;
  logic        wb_valid;
  logic [3:0]  wb_addr;
  logic [19:0] wb_data;
  logic        out_valid, out_ready;
  logic [19:0] out_op0, out_op1;
  logic        rf_wr_en;
  logic [3:0]  rf_wr_addr, rf_rd0_addr, rf_rd1_addr;
  logic [19:0] rf_wr_data, rf_rd0_data, rf_rd1_data;

  regfile_operand_fetch dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_src0(in_src0), .in_src1(in_src1),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_op0(out_op0), .out_op1(out_op1),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .rf_rd0_addr(rf_rd0_addr), .rf_rd1_addr(rf_rd1_addr),
    .rf_rd0_data(rf_rd0_data), .rf_rd1_data(rf_rd1_data)
  );

  always #5 clk = ~clk;

  // register file: synchronous write, registered read returning pre-write data
  logic [19:0] rf_mem [16];
  always @(posedge clk) begin
    if (rf_wr_en) rf_mem[rf_wr_addr] <= rf_wr_data;
    rf_rd0_data <= rf_mem[rf_rd0_addr];
    rf_rd1_data <= rf_mem[rf_rd1_addr];
  end

  logic [19:0] ref_mem [16];
  logic [39:0] sb_q [$];
  int n_cmp = 0;
  int n_fail = 0;

  typedef struct {
    logic [3:0]  src0;
    logic [3:0]  src1;
    logic        wb_v;
    logic [3:0]  wb_a;
    logic [19:0] wb_d;
    logic [19:0] exp0;
    logic [19:0] exp1;
  } vec_t;
  vec_t vecs [7];

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [3:0] a, input logic [19:0] d);
    wb_valid = 1'b1;
    wb_addr  = a;
    wb_data  = d;
    #1;
    check("wr_port", {15'd0, rf_wr_en, rf_wr_addr, rf_wr_data}, {15'd0, 1'b1, a, d});
    step();
    wb_valid = 1'b0;
    ref_mem[a] = d;
  endtask

  // operands are compared when the downstream handshake is about to complete
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_output: got %h_%h expected none", out_op0, out_op1);
      end else begin
        check("operands", {out_op0, out_op1}, sb_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    for (int i = 0; i < 16; i++) begin
      rf_mem[i]  = '0;
      ref_mem[i] = '0;
    end
    rst = 1'b1; in_valid = 0; in_src0 = 0; in_src1 = 0;
    wb_valid = 0; wb_addr = 0; wb_data = 0; out_ready = 1'b1;
    step(); step();
    check("reset_ctrl", {38'd0, out_valid, in_ready}, {38'd0, 1'b0, 1'b1});
    check("reset_ops", {out_op0, out_op1}, 40'd0);
    check("reset_rd_addr", {32'd0, rf_rd0_addr, rf_rd1_addr}, 40'd0);
    rst = 1'b0;
    step();

    write_reg(4'd0,  20'h00077);
    write_reg(4'd1,  20'h11111);
    write_reg(4'd3,  20'h12345);
    write_reg(4'd5,  20'h00001);
    write_reg(4'd6,  20'h06666);
    write_reg(4'd7,  20'h0ABCD);
    write_reg(4'd15, 20'hABCDE);
    step();

    vecs[0] = '{4'd3, 4'd7,  1'b0, 4'd0, 20'h00000, 20'h12345, 20'h0ABCD};
    vecs[1] = '{4'd5, 4'd5,  1'b1, 4'd5, 20'hFFFFF, 20'hFFFFF, 20'hFFFFF};
    vecs[2] = '{4'd0, 4'd15, 1'b0, 4'd0, 20'h00000, 20'h00077, 20'hABCDE};
    vecs[3] = '{4'd1, 4'd3,  1'b1, 4'd3, 20'h22222, 20'h11111, 20'h22222};
    vecs[4] = '{4'd7, 4'd7,  1'b1, 4'd1, 20'h33333, 20'h0ABCD, 20'h0ABCD};
    vecs[5] = '{4'd3, 4'd0,  1'b1, 4'd0, 20'h00000, 20'h22222, 20'h00000};
    vecs[6] = '{4'd5, 4'd1,  1'b0, 4'd0, 20'h00000, 20'hFFFFF, 20'h33333};

    for (int i = 0; i < 7; i++) begin
      v = vecs[i];
      in_valid = 1'b1; in_src0 = v.src0; in_src1 = v.src1;
      wb_valid = v.wb_v; wb_addr = v.wb_a; wb_data = v.wb_d;
      #1;
      check("accept_ready", {39'd0, in_ready}, 40'd1);
      check("accept_rd_addr", {32'd0, rf_rd0_addr, rf_rd1_addr}, {32'd0, v.src0, v.src1});
      sb_q.push_back({v.exp0, v.exp1});
      step();
      in_valid = 1'b0; wb_valid = 1'b0;
      if (v.wb_v) ref_mem[v.wb_a] = v.wb_d;
      check("lat_read", {39'd0, out_valid}, 40'd0);
      step();
      check("lat_hold", {39'd0, out_valid}, 40'd1);
      step();
      check("consumed", {39'd0, out_valid}, 40'd0);
    end

    // writeback landing in the READ cycle
    write_reg(4'd2, 20'h00010);
    write_reg(4'd4, 20'h00044);
    in_valid = 1'b1; in_src0 = 4'd2; in_src1 = 4'd4;
    sb_q.push_back({20'h00042, 20'h00044});
    step();
    in_valid = 1'b0;
    wb_valid = 1'b1; wb_addr = 4'd2; wb_data = 20'h00042;
    step();
    wb_valid = 1'b0; ref_mem[2] = 20'h00042;
    check("readwb_valid", {39'd0, out_valid}, 40'd1);
    step();

    // stall in HOLD with a forwarded write, then handoff
    out_ready = 1'b0;
    write_reg(4'd8, 20'h08888);
    write_reg(4'd9, 20'h09999);
    in_valid = 1'b1; in_src0 = 4'd8; in_src1 = 4'd9;
    sb_q.push_back({20'h08888, 20'h55555});
    step();
    in_valid = 1'b0;
    step();
    check("hold_first", {out_op0, out_op1}, {20'h08888, 20'h09999});
    step();
    check("hold_stable", {out_op0, out_op1}, {20'h08888, 20'h09999});
    wb_valid = 1'b1; wb_addr = 4'd9; wb_data = 20'h55555;
    step();
    wb_valid = 1'b0; ref_mem[9] = 20'h55555;
    check("hold_fwd", {out_op0, out_op1}, {20'h08888, 20'h55555});
    check("hold_valid", {39'd0, out_valid}, 40'd1);
    check("hold_not_ready", {39'd0, in_ready}, 40'd0);
    step();
    out_ready = 1'b1;
    in_valid = 1'b1; in_src0 = 4'd6; in_src1 = 4'd9;
    sb_q.push_back({20'h06666, 20'h55555});
    #1;
    check("handoff_ready", {39'd0, in_ready}, 40'd1);
    step();
    in_valid = 1'b0;
    check("handoff_read", {39'd0, out_valid}, 40'd0);
    step();
    check("handoff_hold", {39'd0, out_valid}, 40'd1);
    step();

    // continuous requests: one result every two cycles
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_src0 = 4'(i); in_src1 = 4'(15 - i);
      #1;
      check("tput_ready", {39'd0, in_ready}, {39'd0, (i % 2) == 0});
      if (in_ready) sb_q.push_back({ref_mem[i], ref_mem[15 - i]});
      step();
    end
    in_valid = 1'b0;
    step(); step(); step();
    check("tput_drained", 40'(sb_q.size()), 40'd0);

    // reset while a request is in READ
    write_reg(4'd11, 20'h0BBBB);
    in_valid = 1'b1; in_src0 = 4'd11; in_src1 = 4'd11;
    step();
    in_valid = 1'b0;
    check("abort_read", {39'd0, out_valid}, 40'd0);
    rst = 1'b1;
    #1;
    check("abort_ctrl", {38'd0, out_valid, in_ready}, {38'd0, 1'b0, 1'b1});
    check("abort_ops", {out_op0, out_op1}, 40'd0);
    check("abort_rd_addr", {32'd0, rf_rd0_addr, rf_rd1_addr}, 40'd0);
    step(); step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("abort_no_out", {39'd0, out_valid}, 40'd0);
    end

    check("sb_empty", 40'(sb_q.size()), 40'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
